// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - instruction issue controller: fetch queue, head decode, single-issue dispatch
// The decoder and the issue controller that feeds its head entry through it.

module decoder #(
   parameter int OP_W = 6
) (
   input  logic [31:0]     inst_i,
   output logic [OP_W-1:0] op_o,
   output logic [4:0]      rd_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [31:0]     imm_o,
   output logic            legal_o,
   output logic            is_ls_o,
   output logic            is_store_o,
   output logic            is_branch_o
);
   logic [5:0] op6;
   logic [2:0] f3;
   logic       alt;

   assign f3  = inst_i[14:12];
   assign alt = inst_i[30];
   assign op_o = OP_W'(op6);

   // op layout: 1..4 U/J classes, then {class, alt, funct3} for branch/load/store/op-imm/op
   always_comb begin
      op6 = '0; rd_o = '0; rs1_o = '0; rs2_o = '0; imm_o = '0;
      legal_o = 1'b1; is_ls_o = 1'b0; is_store_o = 1'b0; is_branch_o = 1'b0;
      case (inst_i[6:0])
         7'b0110111: begin op6 = 6'd1; rd_o = inst_i[11:7]; imm_o = {inst_i[31:12], 12'b0}; end
         7'b0010111: begin op6 = 6'd2; rd_o = inst_i[11:7]; imm_o = {inst_i[31:12], 12'b0}; end
         7'b1101111: begin
            op6 = 6'd3; rd_o = inst_i[11:7];
            imm_o = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
         end
         7'b1100111: begin
            op6 = 6'd4; rd_o = inst_i[11:7]; rs1_o = inst_i[19:15];
            imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         7'b1100011: begin
            op6 = {3'b001, f3}; rs1_o = inst_i[19:15]; rs2_o = inst_i[24:20]; is_branch_o = 1'b1;
            imm_o = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
         end
         7'b0000011: begin
            op6 = {3'b010, f3}; rd_o = inst_i[11:7]; rs1_o = inst_i[19:15]; is_ls_o = 1'b1;
            imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         7'b0100011: begin
            op6 = {3'b011, f3}; rs1_o = inst_i[19:15]; rs2_o = inst_i[24:20];
            is_ls_o = 1'b1; is_store_o = 1'b1;
            imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         end
         7'b0010011: begin
            op6 = {2'b10, alt & (f3 == 3'd5), f3}; rd_o = inst_i[11:7]; rs1_o = inst_i[19:15];
            imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         7'b0110011: begin
            op6 = {2'b11, alt & ((f3 == 3'd0) | (f3 == 3'd5)), f3};
            rd_o = inst_i[11:7]; rs1_o = inst_i[19:15]; rs2_o = inst_i[24:20];
         end
         default: legal_o = 1'b0;
      endcase
   end
endmodule

module issue_ctrl #(
   parameter int DEPTH = 4,
   parameter int OP_W  = 6,
   parameter int ROB_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rdy_i,
   input  logic             if_valid_i,
   input  logic [31:0]      if_inst_i,
   input  logic [31:0]      if_pc_i,
   input  logic             if_pred_taken_i,
   output logic             if_ready_o,
   input  logic             rob_full_i,
   input  logic             rs_full_i,
   input  logic             lsb_full_i,
   input  logic [ROB_W-1:0] rob_tail_i,
   input  logic             flush_i,
   output logic             dsp_valid_o,
   output logic [OP_W-1:0]  dsp_op_o,
   output logic [4:0]       dsp_rd_o,
   output logic [4:0]       dsp_rs1_o,
   output logic [4:0]       dsp_rs2_o,
   output logic [31:0]      dsp_imm_o,
   output logic [31:0]      dsp_pc_o,
   output logic             dsp_pred_taken_o,
   output logic [ROB_W-1:0] dsp_tag_o,
   output logic             dsp_to_lsb_o,
   output logic             dsp_is_store_o,
   output logic             dsp_is_branch_o
);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pred;
   } entry_t;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [31:0]      imm;
      logic [31:0]      pc;
      logic             pred;
      logic [ROB_W-1:0] tag;
      logic             to_lsb;
      logic             is_store;
      logic             is_branch;
   } dsp_t;

   entry_t          mem_q [DEPTH];
   entry_t          head_ent;
   logic [PW:0]     head_q, head_d, tail_q, tail_d, count;
   logic            full, empty, push, head_ok, issue, drop;
   logic            dsp_valid_q, dsp_valid_d;
   dsp_t            dsp_q, dsp_d;
   logic [OP_W-1:0] dec_op;
   logic [4:0]      dec_rd, dec_rs1, dec_rs2;
   logic [31:0]     dec_imm;
   logic            dec_legal, dec_ls, dec_store, dec_branch;

   assign head_ent = mem_q[head_q[PW-1:0]];

   decoder #(.OP_W(OP_W)) u_dec (
      .inst_i      (head_ent.inst),
      .op_o        (dec_op),
      .rd_o        (dec_rd),
      .rs1_o       (dec_rs1),
      .rs2_o       (dec_rs2),
      .imm_o       (dec_imm),
      .legal_o     (dec_legal),
      .is_ls_o     (dec_ls),
      .is_store_o  (dec_store),
      .is_branch_o (dec_branch)
   );

   always_comb begin
      count      = tail_q - head_q;
      full       = (count == (PW+1)'(DEPTH));
      empty      = (count == '0);
      if_ready_o = !rst_i && !full;
      push       = if_valid_i && if_ready_o && rdy_i && !flush_i;
      head_ok    = rdy_i && !flush_i && !empty;
      issue      = head_ok && dec_legal && !rob_full_i && (dec_ls ? !lsb_full_i : !rs_full_i);
      // Illegal words are discarded without waiting on back-end space.
      drop       = head_ok && !dec_legal;
      head_d      = head_q + (PW+1)'(issue | drop);
      tail_d      = tail_q + (PW+1)'(push);
      dsp_valid_d = issue;
      dsp_d       = dsp_q;
      if (issue) begin
         dsp_d = '{op: dec_op, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, imm: dec_imm,
                   pc: head_ent.pc, pred: head_ent.pred, tag: rob_tail_i,
                   to_lsb: dec_ls, is_store: dec_store, is_branch: dec_branch};
      end
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q      <= '0;
         tail_q      <= '0;
         dsp_valid_q <= 1'b0;
         dsp_q       <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         dsp_valid_q <= dsp_valid_d;
         dsp_q       <= dsp_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[tail_q[PW-1:0]] <= '{inst: if_inst_i, pc: if_pc_i, pred: if_pred_taken_i};
   end

   assign dsp_valid_o      = dsp_valid_q;
   assign dsp_op_o         = dsp_q.op;
   assign dsp_rd_o         = dsp_q.rd;
   assign dsp_rs1_o        = dsp_q.rs1;
   assign dsp_rs2_o        = dsp_q.rs2;
   assign dsp_imm_o        = dsp_q.imm;
   assign dsp_pc_o         = dsp_q.pc;
   assign dsp_pred_taken_o = dsp_q.pred;
   assign dsp_tag_o        = dsp_q.tag;
   assign dsp_to_lsb_o     = dsp_q.to_lsb;
   assign dsp_is_store_o   = dsp_q.is_store;
   assign dsp_is_branch_o  = dsp_q.is_branch;
endmodule
